bus_xcvr_ctrl: RTL and testbench

BUS_XCVR_CTRL -- requirements
Module: bus_xcvr_ctrl

---
 rtl/bus_xcvr_ctrl.sv | 158 +++++++++++++++
 tb/tb_bus_xcvr_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/bus_xcvr_ctrl.sv
// Bus transceiver controller: round-robin arbitration between two requesters, turnaround,
// setup and active phases for an external transceiver. Optional timeout: BUS_XCVR_CTRL_TIMEOUT_EN.
module bus_xcvr_ctrl #(
  parameter int unsigned SETUP_CYC      = 1,
  parameter int unsigned MIN_ACTIVE_CYC = 2,
  parameter int unsigned TURN_CYC       = 1,
  parameter int unsigned TIMEOUT_CYC    = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] dir,
  input  logic       ext_rdy,
  output logic       xcvr_cs_n,
  output logic       xcvr_dce,
  output logic [1:0] gnt,
  output logic [1:0] ack,
  output logic       err,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TURN,
    S_SETUP,
    S_ACTIVE,
    S_DONE
  } state_t;

`ifdef BUS_XCVR_CTRL_TIMEOUT_EN
  localparam int unsigned CW = 8;
`else
  localparam int unsigned CW = 4;
`endif

  localparam logic [CW-1:0] SETUP_N  = CW'(SETUP_CYC);
  localparam logic [CW-1:0] MIN_N    = CW'(MIN_ACTIVE_CYC);
  localparam logic [CW-1:0] TURN_N   = CW'(TURN_CYC);

  if (SETUP_CYC < 1 || SETUP_CYC > 15 || MIN_ACTIVE_CYC < 1 || MIN_ACTIVE_CYC > 15 ||
      TURN_CYC < 1 || TURN_CYC > 15 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_param_check
    $error("bus_xcvr_ctrl: timing parameter out of range");
  end

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          last_gnt;
  logic          tgt_dir;
  logic          win;

  // Tie goes to the requester that was not granted last.
  always_comb begin
    win = 1'b0;
    case (req)
      2'b10:   win = 1'b1;
      2'b11:   win = ~last_gnt;
      default: win = 1'b0;
    endcase
  end

  // Counter saturates so a stalled ACTIVE phase never wraps back below MIN_N.
  always_comb begin
    cnt_inc = (cnt == '1) ? cnt : cnt + CW'(1);
  end

`ifdef BUS_XCVR_CTRL_TIMEOUT_EN
  localparam logic [CW-1:0] TO_N = CW'(TIMEOUT_CYC);
  logic err_r;
  assign err = err_r;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      last_gnt  <= 1'b1;
      tgt_dir   <= 1'b0;
      xcvr_cs_n <= 1'b1;
      xcvr_dce  <= 1'b0;
      gnt       <= '0;
      ack       <= '0;
      busy      <= 1'b0;
`ifdef BUS_XCVR_CTRL_TIMEOUT_EN
      err_r     <= 1'b0;
`endif
    end else begin
      ack <= '0;
`ifdef BUS_XCVR_CTRL_TIMEOUT_EN
      err_r <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (|req) begin
            last_gnt <= win;
            tgt_dir  <= dir[win];
            gnt      <= win ? 2'b10 : 2'b01;
            busy     <= 1'b1;
            cnt      <= CW'(1);
            state    <= (dir[win] != xcvr_dce) ? S_TURN : S_SETUP;
          end
        end
        S_TURN: begin
          if (cnt >= TURN_N) begin
            state    <= S_SETUP;
            xcvr_dce <= tgt_dir;
            cnt      <= CW'(1);
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_SETUP: begin
          if (cnt >= SETUP_N) begin
            state     <= S_ACTIVE;
            xcvr_cs_n <= 1'b0;
            cnt       <= CW'(1);
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_ACTIVE: begin
          if (cnt >= MIN_N && ext_rdy) begin
            state     <= S_DONE;
            xcvr_cs_n <= 1'b1;
            ack       <= gnt;
            cnt       <= '0;
`ifdef BUS_XCVR_CTRL_TIMEOUT_EN
          end else if (cnt >= TO_N) begin
            state     <= S_DONE;
            xcvr_cs_n <= 1'b1;
            ack       <= gnt;
            err_r     <= 1'b1;
            cnt       <= '0;
`endif
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
          cnt   <= '0;
        end
        default: begin
          state     <= S_IDLE;
          xcvr_cs_n <= 1'b1;
          gnt       <= '0;
          busy      <= 1'b0;
          cnt       <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_xcvr_ctrl.sv
// Randomized transaction-level bench for bus_xcvr_ctrl: expected per-cycle outputs are
// derived from each transaction's computed timeline (turn, setup, active length, done).
module tb_bus_xcvr_ctrl;

  localparam int SETUP_CYC      = 1;
  localparam int MIN_ACTIVE_CYC = 2;
  localparam int TURN_CYC       = 1;
  localparam int TIMEOUT_CYC    = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req = 2'b00;
  logic [1:0] dir = 2'b00;
  logic       ext_rdy = 1'b0;
  logic       xcvr_cs_n, xcvr_dce, err, busy;
  logic [1:0] gnt, ack;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bus_xcvr_ctrl #(
    .SETUP_CYC      (SETUP_CYC),
    .MIN_ACTIVE_CYC (MIN_ACTIVE_CYC),
    .TURN_CYC       (TURN_CYC),
    .TIMEOUT_CYC    (TIMEOUT_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .dir       (dir),
    .ext_rdy   (ext_rdy),
    .xcvr_cs_n (xcvr_cs_n),
    .xcvr_dce  (xcvr_dce),
    .gnt       (gnt),
    .ack       (ack),
    .err       (err),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic cs, input logic dce,
                            input logic [1:0] g, input logic [1:0] a,
                            input logic e, input logic b);
    check({tag, ".cs_n"}, 8'(xcvr_cs_n), 8'(cs));
    check({tag, ".dce"},  8'(xcvr_dce),  8'(dce));
    check({tag, ".gnt"},  8'(gnt),       8'(g));
    check({tag, ".ack"},  8'(ack),       8'(a));
    check({tag, ".err"},  8'(err),       8'(e));
    check({tag, ".busy"}, 8'(busy),      8'(b));
  endtask

  initial begin
    logic       m_dce;
    int         m_last;
    int         win, t_turn, a_cyc, k, len, d_cyc, gap;
    logic       wdir, err_e, did_rst;
    logic [1:0] exp_gnt;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    rst_n  = 1'b1;
    m_dce  = 1'b0;
    m_last = 1;

    for (int n = 0; n < 60; n++) begin
      check_outs("idle", 1'b1, m_dce, 2'b00, 2'b00, 1'b0, 1'b0);

      if (req == 2'b00 && n != 0 && $urandom_range(0, 2) == 0) begin
        gap = int'($urandom_range(1, 3));
        for (int g = 0; g < gap; g++) begin
          @(posedge clk);
          #1;
          check_outs("gap", 1'b1, m_dce, 2'b00, 2'b00, 1'b0, 1'b0);
        end
      end

      if (n == 0) begin
        req = 2'b11;
        dir = 2'b00;
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (!req[i] && $urandom_range(0, 1) == 1) begin
            req[i] = 1'b1;
            dir[i] = 1'($urandom_range(0, 1));
          end
        end
        if (req == 2'b00) begin
          win = int'($urandom_range(0, 1));
          req[win] = 1'b1;
          dir[win] = 1'($urandom_range(0, 1));
        end
      end
      ext_rdy = 1'b0;

      if (req == 2'b11) win = 1 - m_last;
      else              win = req[1] ? 1 : 0;
      wdir    = dir[win];
      exp_gnt = (win == 1) ? 2'b10 : 2'b01;
      t_turn  = (wdir != m_dce) ? TURN_CYC : 0;
      a_cyc   = 1 + t_turn + SETUP_CYC;
      k       = int'($urandom_range(0, 6));
      len     = (k + 1 > MIN_ACTIVE_CYC) ? k + 1 : MIN_ACTIVE_CYC;
      err_e   = 1'b0;
`ifdef BUS_XCVR_CTRL_TIMEOUT_EN
      if (len > TIMEOUT_CYC) begin
        len   = TIMEOUT_CYC;
        err_e = 1'b1;
      end
`endif
      d_cyc   = a_cyc + len;
      m_last  = win;
      did_rst = 1'b0;

      for (int c = 1; c <= d_cyc && !did_rst; c++) begin
        @(posedge clk);
        #1;
        check_outs("xfer",
                   !(c >= a_cyc && c < d_cyc),
                   (c <= t_turn) ? m_dce : wdir,
                   exp_gnt,
                   (c == d_cyc) ? exp_gnt : 2'b00,
                   (c == d_cyc) ? err_e : 1'b0,
                   1'b1);
        if (n == 25 && c == a_cyc) begin
          // Async reset mid-ACTIVE: outputs must drop before the next clock edge.
          #2 rst_n = 1'b0;
          #1;
          check_outs("rst_async", 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
          @(posedge clk);
          #1;
          rst_n   = 1'b1;
          ext_rdy = 1'b0;
          m_dce   = 1'b0;
          m_last  = 1;
          did_rst = 1'b1;
        end else begin
          ext_rdy = (c >= a_cyc + k);
          if (c == 1 && $urandom_range(0, 3) == 0) req[win] = 1'b0;
          if (c == d_cyc) req[win] = 1'b0;
        end
      end

      if (!did_rst) begin
        m_dce   = wdir;
        ext_rdy = 1'b0;
        @(posedge clk);
        #1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
